// File: rtl/round_key_adder.sv
// AES-128 AddRoundKey: registers state ^ round key and expands the next key on the fly.
// Latency 1 cycle; no backpressure, accepts an enable every cycle while a key is loaded.
module round_key_adder #(
  parameter int word_size  = 8,
  parameter int array_size = 16
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              key_load,
  input  logic [word_size*array_size-1:0]   cipher_key,
  input  logic                              enable,
  input  logic [word_size*array_size-1:0]   state,
  output logic [31:0]                       sbox_in,
  input  logic [31:0]                       sbox_out,
  output logic [word_size*array_size-1:0]   state_out,
  output logic                              out_valid,
  output logic [3:0]                        round,
  output logic                              key_valid,
  output logic                              last_round
);

  typedef struct packed {
    logic [31:0] w0;
    logic [31:0] w1;
    logic [31:0] w2;
    logic [31:0] w3;
  } key_t;

  key_t        rk;
  logic [7:0]  rcon;
  logic [7:0]  rcon_nxt;
  logic [31:0] w0_nxt, w1_nxt, w2_nxt, w3_nxt;
  logic        accept;

  assign sbox_in = {rk.w3[23:0], rk.w3[31:24]};
  assign accept  = enable & key_valid & ~key_load;

  always_comb begin
    w0_nxt   = rk.w0 ^ sbox_out ^ {rcon, 24'h0};
    w1_nxt   = rk.w1 ^ w0_nxt;
    w2_nxt   = rk.w2 ^ w1_nxt;
    w3_nxt   = rk.w3 ^ w2_nxt;
    rcon_nxt = {rcon[6:0], 1'b0} ^ (rcon[7] ? 8'h1b : 8'h00);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rk         <= '0;
      rcon       <= 8'h01;
      round      <= 4'd0;
      key_valid  <= 1'b0;
      state_out  <= '0;
      out_valid  <= 1'b0;
      last_round <= 1'b0;
    end else begin
      out_valid  <= 1'b0;
      last_round <= 1'b0;
      if (key_load) begin
        rk        <= cipher_key;
        rcon      <= 8'h01;
        round     <= 4'd0;
        key_valid <= 1'b1;
      end else if (accept) begin
        state_out <= state ^ rk;
        out_valid <= 1'b1;
        rk        <= {w0_nxt, w1_nxt, w2_nxt, w3_nxt};
        rcon      <= rcon_nxt;
        // Round 10 is the final key: retire the key and park the counter.
        if (round == 4'd10) begin
          last_round <= 1'b1;
          key_valid  <= 1'b0;
        end else begin
          round <= round + 4'd1;
        end
      end
    end
  end

endmodule
